// File: rtl/nios_sampler_nios2_gen2_0_cpu_debug_slave_seq.sv
// Virtual-JTAG scan sequencer driving the Nios II debug slave TCK domain.
// Define DEBUG_SLAVE_SEQ_RTI_EN to insert a run-test-idle phase after UDR.
module nios_sampler_nios2_gen2_0_cpu_debug_slave_seq #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2,
    parameter int RTI_TCKS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo
);

    localparam int DIV_W   = $clog2(2 * TCK_DIV);
    localparam int CNT_MAX = (RTI_TCKS > DR_WIDTH) ? RTI_TCKS : DR_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] DR_LAST  = CNT_W'(DR_WIDTH - 1);
`ifdef DEBUG_SLAVE_SEQ_RTI_EN
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_TCKS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SHIFT,
        S_UDR,
`ifdef DEBUG_SLAVE_SEQ_RTI_EN
        S_RTI,
`endif
        S_RSP
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div;
    logic [CNT_W-1:0]    cnt;
    logic [DR_WIDTH-1:0] sr;

`ifdef DEBUG_SLAVE_SEQ_RTI_EN
    logic rti_q;
    assign jtag_state_rti = rti_q;
`else
    assign jtag_state_rti = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            div       <= '0;
            cnt       <= '0;
            sr        <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            ir_in     <= '0;
            vs_uir    <= 1'b0;
            vs_cdr    <= 1'b0;
            vs_sdr    <= 1'b0;
            vs_udr    <= 1'b0;
            tck       <= 1'b0;
            tdi       <= 1'b0;
`ifdef DEBUG_SLAVE_SEQ_RTI_EN
            rti_q     <= 1'b0;
`endif
        end else if (state == S_IDLE) begin
            if (cmd_valid) begin
                cmd_ready <= 1'b0;
                ir_in     <= cmd_ir;
                sr        <= cmd_data;
                div       <= '0;
                cnt       <= '0;
                vs_uir    <= 1'b1;
                state     <= S_UIR;
            end
        end else if (state == S_RSP) begin
            if (rsp_ready) begin
                rsp_valid <= 1'b0;
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
            end
        end else if (div == DIV_LAST) begin
            // TCK period boundary: tck falls and strobes change together
            div <= '0;
            tck <= 1'b0;
            case (state)
                S_UIR: begin
                    vs_uir <= 1'b0;
                    vs_cdr <= 1'b1;
                    state  <= S_CDR;
                end
                S_CDR: begin
                    vs_cdr <= 1'b0;
                    vs_sdr <= 1'b1;
                    tdi    <= sr[0];
                    cnt    <= '0;
                    state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (cnt == DR_LAST) begin
                        vs_sdr <= 1'b0;
                        vs_udr <= 1'b1;
                        tdi    <= 1'b0;
                        state  <= S_UDR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        tdi <= sr[0];
                    end
                end
                S_UDR: begin
                    vs_udr <= 1'b0;
`ifdef DEBUG_SLAVE_SEQ_RTI_EN
                    rti_q <= 1'b1;
                    cnt   <= '0;
                    state <= S_RTI;
`else
                    rsp_valid <= 1'b1;
                    rsp_data  <= sr;
                    state     <= S_RSP;
`endif
                end
`ifdef DEBUG_SLAVE_SEQ_RTI_EN
                S_RTI: begin
                    if (cnt == RTI_LAST) begin
                        rti_q     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= sr;
                        state     <= S_RSP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end else begin
            div <= div + DIV_W'(1);
            if (div == DIV_RISE) begin
                tck <= 1'b1;
                if (state == S_SHIFT)
                    sr <= {tdo, sr[DR_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_nios_sampler_nios2_gen2_0_cpu_debug_slave_seq.sv
// Randomized bench for the debug slave scan sequencer with a scan-level model.
module tb_nios_sampler_nios2_gen2_0_cpu_debug_slave_seq;

    localparam int DRW = 38;
    localparam int IRW = 2;
    localparam int TD  = 2;
    localparam int RT  = 2;
    localparam int P   = 2 * TD;
`ifdef DEBUG_SLAVE_SEQ_RTI_EN
    localparam int RTI_CYC = RT * P;
`else
    localparam int RTI_CYC = 0;
`endif
    localparam int LAT = 1 + (DRW + 3) * P + RTI_CYC;
    localparam logic [10:0] RST_VEC = 11'h400;

    logic           clk;
    logic           reset_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir;
    logic [DRW-1:0] cmd_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [DRW-1:0] rsp_data;
    logic [IRW-1:0] ir_in;
    logic           vs_uir, vs_cdr, vs_sdr, vs_udr;
    logic           jtag_state_rti;
    logic           tck, tdi, tdo;

    int             checks, errors;
    int             mode, k;
    logic           cval;
    logic [DRW-1:0] rnd_word;
    logic           pend;
    logic [IRW-1:0] nxt_ir;
    logic [DRW-1:0] nxt_data;

    nios_sampler_nios2_gen2_0_cpu_debug_slave_seq #(
        .DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(TD), .RTI_TCKS(RT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ir_in(ir_in),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti),
        .tck(tck), .tdi(tdi), .tdo(tdo)
    );

    // Debug slave stand-in: loopback, constant, or a random word bit by bit
    assign tdo = (mode == 0) ? tdi :
                 (mode == 1) ? cval :
                 ((k < DRW) ? rnd_word[k] : 1'b0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] out_vec();
        return {cmd_ready, rsp_valid, ir_in, vs_uir, vs_cdr, vs_sdr,
                vs_udr, jtag_state_rti, tck, tdi};
    endfunction

    task automatic run_cmd(input logic [IRW-1:0] ir, input logic [DRW-1:0] data,
                           input int md, input logic cv, input int hold,
                           input int abort_at);
        int t, per, n_uir, n_cdr, n_sdr, n_udr, n_rti;
        int tdi_err, viol, seq_err, hv;
        logic [4:0] exp_s;
        logic [DRW-1:0] exp;
        logic prev_tck;
        bit aborted;
        check("ready_pre", cmd_ready, 1);
        mode = md;
        cval = cv;
        k = 0;
        rnd_word = DRW'({$urandom(), $urandom()});
        exp = (md == 0) ? data : (md == 1) ? {DRW{cv}} : rnd_word;
        cmd_valid = 1'b1;
        cmd_ir = ir;
        cmd_data = data;
        rsp_ready = (hold == 0);
        @(negedge clk);
        cmd_ir = IRW'($urandom());
        cmd_data = DRW'({$urandom(), $urandom()});
        t = 1; prev_tck = 1'b0; aborted = 0;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
        tdi_err = 0; viol = 0; seq_err = 0;
        forever begin
            if (rsp_valid || t > LAT + 50) break;
            n_uir += int'(vs_uir);
            n_cdr += int'(vs_cdr);
            n_sdr += int'(vs_sdr);
            n_udr += int'(vs_udr);
            n_rti += int'(jtag_state_rti);
            per = (t - 1) / P;
            if (per == 0)             exp_s = 5'b10000;
            else if (per == 1)        exp_s = 5'b01000;
            else if (per < DRW + 2)   exp_s = 5'b00100;
            else if (per == DRW + 2)  exp_s = 5'b00010;
            else                      exp_s = 5'b00001;
            if ({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti} !== exp_s)
                seq_err++;
            if (tck !== (((t - 1) % P) >= TD)) viol++;
            if (cmd_ready !== 1'b0) viol++;
            if (tdi && !vs_sdr) viol++;
            if (vs_sdr && tck && !prev_tck) begin
                if (k < DRW && tdi !== data[k]) tdi_err++;
                k++;
            end
            prev_tck = tck;
            if (abort_at >= 0 && k == abort_at) begin
                aborted = 1;
                break;
            end
            cmd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b0;
        if (aborted) begin
            reset_n = 1'b0;
            @(negedge clk);
            check("abort_rst", out_vec(), RST_VEC);
            check("abort_data", rsp_data, 0);
            reset_n = 1'b1;
            viol = 0;
            repeat (200) begin
                @(negedge clk);
                if (out_vec() !== RST_VEC || rsp_data !== '0) viol++;
            end
            check("abort_quiet", viol, 0);
            mode = 0;
            return;
        end
        check("latency", t, LAT);
        check("n_uir", n_uir, P);
        check("n_cdr", n_cdr, P);
        check("n_sdr", n_sdr, DRW * P);
        check("n_udr", n_udr, P);
        check("n_rti", n_rti, RTI_CYC);
        check("strobe_seq", seq_err, 0);
        check("tdi_bits", tdi_err, 0);
        check("tck_rises", k, DRW);
        check("viol", viol, 0);
        check("rsp_data", rsp_data, exp);
        check("ir_in", ir_in, ir);
        hv = 0;
        if (hold > 0) begin
            cmd_valid = pend;
            cmd_ir = nxt_ir;
            cmd_data = nxt_data;
            repeat (hold) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== exp || cmd_ready || tck || tdi)
                    hv++;
            end
            check("hold", hv, 0);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
        check("ir_keep", ir_in, ir);
        cmd_valid = pend;
    endtask

    initial begin
        checks = 0; errors = 0;
        mode = 1; cval = 1'b0; k = 0; rnd_word = '0;
        pend = 1'b0; nxt_ir = '0; nxt_data = '0;
        reset_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_ir = 2'b11;
        cmd_data = '1;
        rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset", out_vec(), RST_VEC);
            check("reset_data", rsp_data, 0);
        end
        reset_n = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("idle", out_vec(), RST_VEC);

        run_cmd(2'b10, 38'h15_A5A5_A5A5, 0, 1'b0, 0, -1);
        run_cmd(2'b01, '0, 1, 1'b1, 0, -1);

        pend = 1'b1;
        nxt_ir = IRW'($urandom());
        nxt_data = DRW'({$urandom(), $urandom()});
        run_cmd(IRW'($urandom()), DRW'({$urandom(), $urandom()}), 2, 1'b0, 10, -1);
        pend = 1'b0;
        run_cmd(nxt_ir, nxt_data, 2, 1'b0, 0, -1);

        run_cmd(2'b11, DRW'({$urandom(), $urandom()}), 0, 1'b0, 0, 20);
        run_cmd(2'b01, DRW'({$urandom(), $urandom()}), 2, 1'b0, 0, -1);

        repeat (6)
            run_cmd(IRW'($urandom()), DRW'({$urandom(), $urandom()}),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
